// File: rtl/fact_arb.sv
// Round-robin arbiter/sequencer sharing one factorial core between NREQ requesters.
// It latches the winner's operand, pulses go, and waits for done/err under a watchdog.
// The result goes back to the owner with a one-cycle ack.
module fact_arb #(
   parameter  int unsigned NREQ    = 2,
   parameter  int unsigned NW      = 4,
   parameter  int unsigned W       = 32,
   parameter  int unsigned TIMEOUT = 1024,
   localparam int unsigned OW      = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*NW-1:0] req_n,
   output logic [NREQ-1:0]  ack,
   output logic [W-1:0]     rsp_nf,
   output logic             rsp_err,
   output logic             rsp_tmo,
   output logic             busy,
   output logic [OW-1:0]    owner,
   output logic [W-1:0]     f_n,
   output logic             f_go,
   input  logic             f_done,
   input  logic             f_err,
   input  logic [W-1:0]     f_nf
);

   localparam int unsigned TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [W-1:0]    rsp_nf_q, rsp_nf_d;
   logic            rsp_err_q, rsp_err_d;
   logic            rsp_tmo_q, rsp_tmo_d;
   logic            busy_q, busy_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [W-1:0]    f_n_q, f_n_d;
   logic            f_go_q, f_go_d;
   logic [OW-1:0]   last_q, last_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [NREQ-1:0] mask_q, mask_d;

   logic [NREQ-1:0] elig;
   logic [OW-1:0]   cand;
   logic [OW-1:0]   gnt;
   logic            found;
   logic            first_wait;

   // Per-requester operand slices
   logic [NW-1:0] op_a [NREQ];
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_op
      assign op_a[gi] = req_n[gi*NW +: NW];
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ack_q     <= '0;
         rsp_nf_q  <= '0;
         rsp_err_q <= 1'b0;
         rsp_tmo_q <= 1'b0;
         busy_q    <= 1'b0;
         owner_q   <= '0;
         f_n_q     <= '0;
         f_go_q    <= 1'b0;
         last_q    <= OW'(NREQ - 1);
         timer_q   <= '0;
         mask_q    <= '0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         rsp_nf_q  <= rsp_nf_d;
         rsp_err_q <= rsp_err_d;
         rsp_tmo_q <= rsp_tmo_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         f_n_q     <= f_n_d;
         f_go_q    <= f_go_d;
         last_q    <= last_d;
         timer_q   <= timer_d;
         mask_q    <= mask_d;
      end
   end

   // Next-state logic; registered outputs take the value they must show in the next state
   always_comb begin
      state_d   = state_q;
      ack_d     = '0;
      rsp_nf_d  = rsp_nf_q;
      rsp_err_d = rsp_err_q;
      rsp_tmo_d = rsp_tmo_q;
      owner_d   = owner_q;
      f_n_d     = f_n_q;
      f_go_d    = 1'b0;
      last_d    = last_q;
      timer_d   = timer_q;
      mask_d    = mask_q;
      cand      = '0;
      gnt       = '0;
      found     = 1'b0;

      // Round-robin search starting just after the last served requester
      elig = req & ~mask_q;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         cand = OW'((32'(last_q) + off) % NREQ);
         if (!found && elig[cand]) begin
            found = 1'b1;
            gnt   = cand;
         end
      end

      // Timer is zero only in the first WAIT cycle, when core status is still stale
      first_wait = (timer_q == '0);

      case (state_q)
         S_IDLE: begin
            mask_d = '0;
            if (found) begin
               owner_d = gnt;
               f_n_d   = W'(op_a[gnt]);
               f_go_d  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!first_wait && f_err) begin
               rsp_err_d = 1'b1;
               rsp_tmo_d = 1'b0;
               rsp_nf_d  = '0;
               ack_d     = NREQ'(1) << owner_q;
               state_d   = S_RESP;
            end else if (!first_wait && f_done) begin
               rsp_err_d = 1'b0;
               rsp_tmo_d = 1'b0;
               rsp_nf_d  = f_nf;
               ack_d     = NREQ'(1) << owner_q;
               state_d   = S_RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               rsp_err_d = 1'b1;
               rsp_tmo_d = 1'b1;
               rsp_nf_d  = '0;
               ack_d     = NREQ'(1) << owner_q;
               state_d   = S_RESP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_RESP: begin
            last_d  = owner_q;
            mask_d  = NREQ'(1) << owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign ack     = ack_q;
   assign rsp_nf  = rsp_nf_q;
   assign rsp_err = rsp_err_q;
   assign rsp_tmo = rsp_tmo_q;
   assign busy    = busy_q;
   assign owner   = owner_q;
   assign f_n     = f_n_q;
   assign f_go    = f_go_q;

endmodule

// File: doc/fact_arb.md
Name: fact_arb

Overview:
- Round-robin arbiter and sequencer that shares one factorial core between NREQ requesters (e.g. CPU peripheral port and a DMA/second master).
- Latches the winning requester's operand, pulses the core's go and waits for done/err with a watchdog.
- Returns the result to the owner with a one-cycle ack.
- Sits between the requesters and the factorial core's n/go/done/err/nf pins.

Parameters:
NREQ, 2, number of requesters (>=2); OW = $clog2(NREQ) derived, not overridable
NW, 4, operand width per requester
W, 32, core operand/result width; operand zero-extended NW->W
TIMEOUT, 1024, max WAIT cycles before forced abort (>=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  NREQ  level request per requester
req_n  input  NREQ*NW  operands; requester i at [i*NW +: NW]
ack  output  NREQ  one-cycle completion pulse to owner
rsp_nf  output  W  result, valid while ack!=0, held until next response
rsp_err  output  1  core error or timeout, valid with ack
rsp_tmo  output  1  timeout abort, valid with ack
busy  output  1  high in any state other than IDLE
owner  output  OW  current/last granted requester
f_n  output  W  operand to core, stable from ISSUE through WAIT
f_go  output  1  one-cycle start pulse to core
f_done  input  1  core done (level)
f_err  input  1  core error (level)
f_nf  input  W  core result, valid when f_done

Behaviour:
- All outputs registered.
- Reset (rst_n low, asynchronous): state=IDLE, ack=0, rsp_nf=0, rsp_err=0, rsp_tmo=0, busy=0, owner=0, f_go=0, f_n=0, last=NREQ-1, timer=0, mask=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Eligible = req & ~mask.
  - If eligible nonzero: grant first set bit searching last+1, last+2, ... modulo NREQ.
  - Set owner, f_n = zero-extended req_n slice, go to ISSUE. Otherwise stay.
  - mask clears after one IDLE cycle.
- ISSUE: f_go=1 for exactly this cycle; timer=0; go to WAIT.
- WAIT:
  - First WAIT cycle: f_done/f_err ignored, because core status is stale until go is processed.
  - From second WAIT cycle on:
    - If f_err: rsp_err=1, rsp_nf=0.
    - Else if f_done: rsp_nf=f_nf, rsp_err=0.
    - Either case: rsp_tmo=0, go to RESP.
    - f_err wins if both are set.
    - Else timer++; when timer reaches TIMEOUT-1 with no done/err: rsp_err=1, rsp_tmo=1, rsp_nf=0, go to RESP.
- RESP:
  - ack[owner]=1 for this cycle only; last=owner.
  - mask = one-hot(owner), so the previous owner cannot be re-granted in the next IDLE cycle even if its req is still high.
  - Go to IDLE.
- Latency: req sampled in IDLE cycle t; f_go at t+1; earliest ack at t+4 (core done in second WAIT cycle).
- Requester protocol:
  - Hold req and req_n stable until ack; drop req the cycle after ack for single-shot use.
  - req dropped before grant is simply not served.
  - req_n changes after grant are ignored, since the operand is latched.
- Non-owner req edges during ISSUE/WAIT/RESP have no effect until IDLE.
- Fairness: with all reqs continuously high, grants rotate 0,1,...,NREQ-1,0.
- Timeout does not reset the core; the next f_go restarts it. A late f_done after abort is ignored in IDLE and in the first WAIT cycle.
- rsp_nf/rsp_err/rsp_tmo hold their values after ack until the next RESP.
- busy is low only in IDLE.

Test Plan:
- Single requester 0, n=5, mock core done 3 cycles after go → f_go one pulse with f_n=5; ack=2'b01 one cycle; rsp_nf=120, rsp_err=0, rsp_tmo=0.
- req=2'b11 from reset, n0=3, n1=4 → requester 0 first (rsp_nf=6), then requester 1 (rsp_nf=24); ack order 01,10; with reqs held, grants alternate 0,1,0,1.
- Requester 1 alone, req held after ack → no regrant in the IDLE cycle right after RESP; regranted the following cycle.
- Mock core asserts f_err for n=13 → ack with rsp_err=1, rsp_nf=0, rsp_tmo=0. f_done and f_err both high → rsp_err=1.
- TIMEOUT=8, core never responds → ack 8 WAIT cycles after ISSUE with rsp_err=1, rsp_tmo=1, rsp_nf=0; stale f_done=1 held from a prior op is ignored in the first WAIT cycle.
- rst_n low mid-WAIT (asynchronous, between edges) → busy, f_go, ack and rsp_* go 0 immediately; after release with req=2'b11, requester 0 is granted first.
